// File: rtl/router_nway.sv
// router_nway: NUM_BRANCH-branch <-> trunk router, lockstep merge / scatter split, mode switch after drain; write -> valid one cycle later.
// Outputs hold data/valid under !ready, full inputs drop writes; optional ROUTER_STALL_CNT_EN adds a saturating stall_cnt.

module router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ok, rd_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage needs no reset: count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

module router_nway #(
  parameter  int NUM_BRANCH = 4,
  parameter  int DATA_W     = 29,
  parameter  int FIFO_DEPTH = 2,
  localparam int TRUNK_W    = NUM_BRANCH * DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SEL,
  input  logic [TRUNK_W-1:0]    INPUT_BRANCH,
  input  logic [NUM_BRANCH-1:0] INPUT_BRANCH_WRITE,
  input  logic [TRUNK_W-1:0]    INPUT_TRUNK,
  input  logic                  INPUT_TRUNK_WRITE,
  input  logic [NUM_BRANCH-1:0] OUTPUT_BRANCH_READY,
  input  logic                  OUTPUT_TRUNK_READY,
  output logic [TRUNK_W-1:0]    output_branch,
  output logic [NUM_BRANCH-1:0] output_branch_valid,
  output logic [TRUNK_W-1:0]    output_trunk,
  output logic                  output_trunk_valid,
  output logic [NUM_BRANCH-1:0] input_branch_full,
  output logic                  input_trunk_full,
  output logic                  mode,
  output logic                  drain_busy
`ifdef ROUTER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  typedef enum logic [1:0] {MERGE, SPLIT, DRAIN} state_t;

  state_t                state;
  logic [NUM_BRANCH-1:0] b_full_raw, b_empty;
  logic [TRUNK_W-1:0]    b_rd_cat, t_rd_dat;
  logic                  t_full_raw, t_empty;
  logic                  draining, merge_go, split_go, all_idle, drain_exit;

  assign draining          = (state == DRAIN);
  assign input_branch_full = b_full_raw | {NUM_BRANCH{mode | draining}};
  assign input_trunk_full  = t_full_raw | ~mode | draining;

  // Transfers always follow the registered mode, so DRAIN keeps flushing the old direction.
  assign merge_go = ~mode & ~|b_empty & (~output_trunk_valid | OUTPUT_TRUNK_READY);
  assign split_go = mode & ~t_empty & (&(~output_branch_valid | OUTPUT_BRANCH_READY));

  assign all_idle   = (&b_empty) & t_empty & ~output_trunk_valid & ~|output_branch_valid;
  assign drain_exit = draining & all_idle;

  for (genvar g = 0; g < NUM_BRANCH; g++) begin : g_branch_fifo
    router_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (INPUT_BRANCH_WRITE[g] & ~input_branch_full[g]),
      .wr_dat (INPUT_BRANCH[g*DATA_W +: DATA_W]),
      .rd_en  (merge_go),
      .rd_dat (b_rd_cat[g*DATA_W +: DATA_W]),
      .full   (b_full_raw[g]),
      .empty  (b_empty[g])
    );
  end

  router_fifo #(.W(TRUNK_W), .DEPTH(FIFO_DEPTH)) u_trunk_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (INPUT_TRUNK_WRITE & ~input_trunk_full),
    .wr_dat (INPUT_TRUNK),
    .rd_en  (split_go),
    .rd_dat (t_rd_dat),
    .full   (t_full_raw),
    .empty  (t_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_trunk       <= '0;
      output_trunk_valid <= 1'b0;
    end else if (merge_go) begin
      output_trunk       <= b_rd_cat;
      output_trunk_valid <= 1'b1;
    end else if (OUTPUT_TRUNK_READY) begin
      output_trunk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_branch       <= '0;
      output_branch_valid <= '0;
    end else if (split_go) begin
      output_branch       <= t_rd_dat;
      output_branch_valid <= '1;
    end else begin
      output_branch_valid <= output_branch_valid & ~OUTPUT_BRANCH_READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MERGE;
      mode       <= 1'b0;
      drain_busy <= 1'b0;
    end else begin
      case (state)
        MERGE, SPLIT: begin
          if (SEL != mode) begin
            state      <= DRAIN;
            drain_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (all_idle) begin
            mode       <= SEL;
            drain_busy <= 1'b0;
            state      <= SEL ? SPLIT : MERGE;
          end
        end
        default: state <= MERGE;
      endcase
    end
  end

`ifdef ROUTER_STALL_CNT_EN
  logic stall_now;
  assign stall_now = (output_trunk_valid & ~OUTPUT_TRUNK_READY) |
                     (|(output_branch_valid & ~OUTPUT_BRANCH_READY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt <= '0;
    else if (drain_exit)                       stall_cnt <= '0;
    else if (stall_now && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  logic unused_drain_exit;
  assign unused_drain_exit = drain_exit;
`endif
endmodule

// File: tb/tb_router_nway.sv
// Self-checking bench for router_nway: scoreboard queues filled at stimulus time, checked at each output handshake.
module tb_router_nway;
  localparam int NB = 4;
  localparam int DW = 29;
  localparam int TW = NB * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          SEL;
  logic [TW-1:0] INPUT_BRANCH;
  logic [NB-1:0] INPUT_BRANCH_WRITE;
  logic [TW-1:0] INPUT_TRUNK;
  logic          INPUT_TRUNK_WRITE;
  logic [NB-1:0] OUTPUT_BRANCH_READY;
  logic          OUTPUT_TRUNK_READY;
  logic [TW-1:0] output_branch;
  logic [NB-1:0] output_branch_valid;
  logic [TW-1:0] output_trunk;
  logic          output_trunk_valid;
  logic [NB-1:0] input_branch_full;
  logic          input_trunk_full;
  logic          mode;
  logic          drain_busy;
`ifdef ROUTER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_trunk = 0;

  logic [TW-1:0] trunk_q [$];
  logic [DW-1:0] br_q [NB][$];
  logic [TW-1:0] mon_t;
  logic [DW-1:0] mon_b;

  router_nway #(.NUM_BRANCH(NB), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .SEL                 (SEL),
    .INPUT_BRANCH        (INPUT_BRANCH),
    .INPUT_BRANCH_WRITE  (INPUT_BRANCH_WRITE),
    .INPUT_TRUNK         (INPUT_TRUNK),
    .INPUT_TRUNK_WRITE   (INPUT_TRUNK_WRITE),
    .OUTPUT_BRANCH_READY (OUTPUT_BRANCH_READY),
    .OUTPUT_TRUNK_READY  (OUTPUT_TRUNK_READY),
    .output_branch       (output_branch),
    .output_branch_valid (output_branch_valid),
    .output_trunk        (output_trunk),
    .output_trunk_valid  (output_trunk_valid),
    .input_branch_full   (input_branch_full),
    .input_trunk_full    (input_trunk_full),
    .mode                (mode),
    .drain_busy          (drain_busy)
`ifdef ROUTER_STALL_CNT_EN
    ,
    .stall_cnt           (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // A valid&&ready seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (output_trunk_valid && OUTPUT_TRUNK_READY) begin
        n_trunk++;
        checks++;
        if (trunk_q.size() == 0) begin
          errors++;
          $display("FAIL trunk_unexpected: got %h, expected no word", output_trunk);
        end else begin
          mon_t = trunk_q.pop_front();
          if (output_trunk !== mon_t) begin
            errors++;
            $display("FAIL trunk_data: got %h expected %h", output_trunk, mon_t);
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (output_branch_valid[i] && OUTPUT_BRANCH_READY[i]) begin
          checks++;
          if (br_q[i].size() == 0) begin
            errors++;
            $display("FAIL branch%0d_unexpected: got %h, expected no word", i, output_branch[i*DW +: DW]);
          end else begin
            mon_b = br_q[i].pop_front();
            if (output_branch[i*DW +: DW] !== mon_b) begin
              errors++;
              $display("FAIL branch%0d_data: got %h expected %h", i, output_branch[i*DW +: DW], mon_b);
            end
          end
        end
      end
    end
  end

  function automatic logic [TW-1:0] mk(input int base);
    logic [TW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_split(input logic [TW-1:0] w);
    for (int i = 0; i < NB; i++) br_q[i].push_back(w[i*DW +: DW]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SEL = 1'b0;
    INPUT_BRANCH = '0;
    INPUT_BRANCH_WRITE = '0;
    INPUT_TRUNK = '0;
    INPUT_TRUNK_WRITE = 1'b0;
    OUTPUT_BRANCH_READY = '1;
    OUTPUT_TRUNK_READY = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (output_trunk_valid !== 1'b0 || output_trunk !== '0) begin errors++; $display("FAIL reset_trunk: got v=%b d=%h expected v=0 d=0", output_trunk_valid, output_trunk); end
    checks++; if (output_branch_valid !== '0 || output_branch !== '0) begin errors++; $display("FAIL reset_branch: got v=%b d=%h expected v=0 d=0", output_branch_valid, output_branch); end
    checks++; if (mode !== 1'b0 || drain_busy !== 1'b0) begin errors++; $display("FAIL reset_mode: got mode=%b busy=%b expected 0 0", mode, drain_busy); end
    checks++; if (input_branch_full !== 4'h0 || input_trunk_full !== 1'b1) begin errors++; $display("FAIL reset_full: got b=%h t=%b expected b=0 t=1", input_branch_full, input_trunk_full); end
  endtask

  task automatic test_merge_basic();
    logic [TW-1:0] e;
    e = mk(1);
    INPUT_BRANCH = e;
    INPUT_BRANCH_WRITE = 4'hF;
    trunk_q.push_back(e);
    tick();
    INPUT_BRANCH_WRITE = '0;
    checks++; if (output_trunk_valid !== 1'b0) begin errors++; $display("FAIL merge_early: got valid=%b expected 0", output_trunk_valid); end
    tick();
    checks++; if (output_trunk_valid !== 1'b1 || output_trunk !== {29'h4, 29'h3, 29'h2, 29'h1}) begin errors++; $display("FAIL merge_basic: got v=%b d=%h expected v=1 d=%h", output_trunk_valid, output_trunk, {29'h4, 29'h3, 29'h2, 29'h1}); end
    tick();
    checks++; if (output_trunk_valid !== 1'b0) begin errors++; $display("FAIL merge_one_cycle: got valid=%b expected 0", output_trunk_valid); end
  endtask

  task automatic test_merge_lockstep();
    logic [TW-1:0] e;
    for (int k = 0; k < 3; k++) begin
      INPUT_BRANCH = mk(32'h100 * (k + 1));
      INPUT_BRANCH_WRITE = 4'b0111;
      tick();
      checks++; if (output_trunk_valid !== 1'b0) begin errors++; $display("FAIL lockstep_no_trunk: write %0d got valid=%b expected 0", k, output_trunk_valid); end
      checks++; if (input_branch_full !== ((k >= 1) ? 4'b0111 : 4'b0000)) begin errors++; $display("FAIL lockstep_full: write %0d got %b expected %b", k, input_branch_full, (k >= 1) ? 4'b0111 : 4'b0000); end
    end
    for (int w = 0; w < 2; w++) begin
      e = mk(32'h100 * (w + 1));
      e[3*DW +: DW] = DW'(32'h33 + 32'h11 * w);
      trunk_q.push_back(e);
      INPUT_BRANCH[3*DW +: DW] = e[3*DW +: DW];
      INPUT_BRANCH_WRITE = 4'b1000;
      tick();
      INPUT_BRANCH_WRITE = '0;
      tick();
      checks++; if (output_trunk_valid !== 1'b1 || output_trunk !== e) begin errors++; $display("FAIL lockstep_word%0d: got v=%b d=%h expected v=1 d=%h", w, output_trunk_valid, output_trunk, e); end
      tick();
      checks++; if (output_trunk_valid !== 1'b0) begin errors++; $display("FAIL lockstep_single%0d: got valid=%b expected 0", w, output_trunk_valid); end
    end
    checks++; if (input_branch_full !== 4'h0) begin errors++; $display("FAIL lockstep_empty: got full=%b expected 0000", input_branch_full); end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] prev;
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      INPUT_BRANCH = mk(32'h500 + 16 * k);
      INPUT_BRANCH_WRITE = 4'hF;
      trunk_q.push_back(INPUT_BRANCH);
      tick();
      if (k >= 1) begin
        checks++; if (output_trunk_valid !== 1'b1 || output_trunk !== prev) begin errors++; $display("FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", k, output_trunk_valid, output_trunk, prev); end
      end
      prev = INPUT_BRANCH;
    end
    INPUT_BRANCH_WRITE = '0;
    tick();
    checks++; if (output_trunk_valid !== 1'b1 || output_trunk !== prev) begin errors++; $display("FAIL b2b_last: got v=%b d=%h expected v=1 d=%h", output_trunk_valid, output_trunk, prev); end
    tick();
    checks++; if (output_trunk_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got valid=%b expected 0", output_trunk_valid); end
  endtask

  task automatic test_mode_drain();
    int n0;
    OUTPUT_TRUNK_READY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      INPUT_BRANCH = mk(32'h700 + 32'h80 * k);
      INPUT_BRANCH_WRITE = 4'hF;
      trunk_q.push_back(INPUT_BRANCH);
      tick();
    end
    INPUT_BRANCH_WRITE = '0;
    SEL = 1'b1;
    tick();
    checks++; if (drain_busy !== 1'b1 || mode !== 1'b0) begin errors++; $display("FAIL drain_enter: got busy=%b mode=%b expected 1 0", drain_busy, mode); end
    checks++; if (input_branch_full !== 4'hF || input_trunk_full !== 1'b1) begin errors++; $display("FAIL drain_full: got b=%h t=%b expected b=F t=1", input_branch_full, input_trunk_full); end
    n0 = n_trunk;
    OUTPUT_TRUNK_READY = 1'b1;
    for (int c = 0; c < 20 && drain_busy; c++) tick();
    checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL drain_timeout: got busy=%b expected 0 within 20 cycles", drain_busy); end
    checks++; if (n_trunk - n0 !== 2) begin errors++; $display("FAIL drain_words: got %0d words expected 2", n_trunk - n0); end
    checks++; if (mode !== 1'b1 || input_trunk_full !== 1'b0 || input_branch_full !== 4'hF) begin errors++; $display("FAIL drain_exit: got mode=%b t=%b b=%h expected 1 0 F", mode, input_trunk_full, input_branch_full); end
  endtask

  task automatic test_split_backpressure();
    logic [TW-1:0] w1, w2;
    w1 = mk(32'h900);
    w2 = mk(32'h980);
    OUTPUT_BRANCH_READY = 4'b1011;
    INPUT_TRUNK = w1;
    INPUT_TRUNK_WRITE = 1'b1;
    push_split(w1);
    tick();
    INPUT_TRUNK = w2;
    push_split(w2);
    tick();
    INPUT_TRUNK_WRITE = 1'b0;
    checks++; if (output_branch_valid !== 4'hF || output_branch !== w1) begin errors++; $display("FAIL split_load: got v=%b d=%h expected v=F d=%h", output_branch_valid, output_branch, w1); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (output_branch_valid !== 4'b0100 || output_branch !== w1) begin errors++; $display("FAIL split_hold%0d: got v=%b d=%h expected v=0100 d=%h", c, output_branch_valid, output_branch, w1); end
    end
    OUTPUT_BRANCH_READY = 4'hF;
    tick();
    checks++; if (output_branch_valid !== 4'hF || output_branch !== w2) begin errors++; $display("FAIL split_second: got v=%b d=%h expected v=F d=%h", output_branch_valid, output_branch, w2); end
    tick();
    checks++; if (output_branch_valid !== 4'h0) begin errors++; $display("FAIL split_done: got v=%b expected 0", output_branch_valid); end
  endtask

  task automatic test_async_reset();
    logic [TW-1:0] e;
    OUTPUT_BRANCH_READY = 4'h0;
    INPUT_TRUNK_WRITE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      INPUT_TRUNK = mk(32'hB00 + 32'h10 * k);
      tick();
    end
    INPUT_TRUNK_WRITE = 1'b0;
    #2;
    rst_n = 1'b0;
    trunk_q.delete();
    for (int i = 0; i < NB; i++) br_q[i].delete();
    #1;
    checks++; if (output_branch_valid !== 4'h0 || output_branch !== '0 || output_trunk_valid !== 1'b0) begin errors++; $display("FAIL areset_outputs: got bv=%b bd=%h tv=%b expected 0", output_branch_valid, output_branch, output_trunk_valid); end
    checks++; if (mode !== 1'b0 || drain_busy !== 1'b0) begin errors++; $display("FAIL areset_mode: got mode=%b busy=%b expected 0 0", mode, drain_busy); end
    SEL = 1'b0;
    OUTPUT_BRANCH_READY = 4'hF;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (input_branch_full !== 4'h0 || input_trunk_full !== 1'b1) begin errors++; $display("FAIL areset_counts: got b=%h t=%b expected b=0 t=1", input_branch_full, input_trunk_full); end
    e = mk(32'hA00);
    INPUT_BRANCH = e;
    INPUT_BRANCH_WRITE = 4'hF;
    trunk_q.push_back(e);
    tick();
    INPUT_BRANCH_WRITE = '0;
    tick();
    checks++; if (output_trunk_valid !== 1'b1 || output_trunk !== e) begin errors++; $display("FAIL areset_merge: got v=%b d=%h expected v=1 d=%h", output_trunk_valid, output_trunk, e); end
    tick();
  endtask

  task automatic test_stall_cnt();
`ifdef ROUTER_STALL_CNT_EN
    OUTPUT_TRUNK_READY = 1'b0;
    INPUT_BRANCH = mk(32'hC00);
    INPUT_BRANCH_WRITE = 4'hF;
    trunk_q.push_back(INPUT_BRANCH);
    tick();
    INPUT_BRANCH_WRITE = '0;
    repeat (70000) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h expected FFFF", stall_cnt); end
    OUTPUT_TRUNK_READY = 1'b1;
    repeat (3) tick();
`endif
  endtask

  initial begin
    test_reset();
    test_merge_basic();
    test_merge_lockstep();
    test_back_to_back();
    test_mode_drain();
    test_split_backpressure();
    test_async_reset();
    test_stall_cnt();
    repeat (3) tick();
    checks++; if (trunk_q.size() != 0) begin errors++; $display("FAIL trunk_leftover: got %0d words pending expected 0", trunk_q.size()); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (br_q[i].size() != 0) begin errors++; $display("FAIL branch%0d_leftover: got %0d words pending expected 0", i, br_q[i].size()); end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
